// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter
//
// Purpose: arbitrates requests from NumPorts L1 cache clients onto one memory
// adapter port, and routes the adapter's returns back to the issuing client.
//   - Round-robin grant among eligible ports. A port is eligible while it is
//     requesting and has fewer than MaxOutstanding un-returned transactions.
//   - The outgoing transaction ID is {port index, client tid}. The port field
//     steers the return. It is stripped before the return reaches the client.
//   - Once presented, a request stays locked to its grantee until acked.
//   - Returns are registered, so a return reaches the client one cycle after
//     it arrives from the adapter.
//   - route_err_o is sticky. It is set by a return whose port field is out of
//     range, or by a return to a port that has nothing outstanding.
//
// Optional build macro: WT_ARB_PORT0_PRIO_EN
//   Defined:   port 0 has strict priority whenever it is eligible and the
//              arbiter is unlocked. Ports 1..NumPorts-1 rotate among
//              themselves, and the pointer never advances to 0.
//   Undefined: pure round-robin over all ports.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   port_req_i/ack_o       per-port request valid (held until acked) / 1-cycle ack
//   port_addr_i, port_wdata_i, port_be_i, port_we_i, port_tid_i
//                          flattened per-port request fields
//   port_rtrn_vld_o        one-hot (or zero) return valid
//   port_rtrn_data_o       shared return data
//   port_rtrn_tid_o        return tid with the port field removed
//   mem_req_o/mem_ack_i    request handshake towards the adapter
//   mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o, mem_tid_o
//                          fields of the granted request
//   mem_rtrn_vld_i, mem_rtrn_data_i, mem_rtrn_tid_i
//                          return channel from the adapter
//   route_err_o            sticky routing/underflow error
//
// Handshake (both sides): a requester raises req together with its fields and
// holds both stable until it sees ack. The transfer happens in the cycle where
// req and ack are both high. An ack seen while req is low has no effect.
module wt_mem_req_arbiter #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned TxIdWidth      = 2,
  parameter int unsigned AddrWidth      = 56,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned PortIdWidth    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumPorts-1:0]               port_req_i,
  output logic [NumPorts-1:0]               port_ack_o,
  input  logic [NumPorts*AddrWidth-1:0]     port_addr_i,
  input  logic [NumPorts*DataWidth-1:0]     port_wdata_i,
  input  logic [NumPorts*(DataWidth/8)-1:0] port_be_i,
  input  logic [NumPorts-1:0]               port_we_i,
  input  logic [NumPorts*TxIdWidth-1:0]     port_tid_i,
  output logic [NumPorts-1:0]               port_rtrn_vld_o,
  output logic [DataWidth-1:0]              port_rtrn_data_o,
  output logic [TxIdWidth-1:0]              port_rtrn_tid_o,
  output logic                              mem_req_o,
  input  logic                              mem_ack_i,
  output logic [AddrWidth-1:0]              mem_addr_o,
  output logic [DataWidth-1:0]              mem_wdata_o,
  output logic [DataWidth/8-1:0]            mem_be_o,
  output logic                              mem_we_o,
  output logic [PortIdWidth+TxIdWidth-1:0]  mem_tid_o,
  input  logic                              mem_rtrn_vld_i,
  input  logic [DataWidth-1:0]              mem_rtrn_data_i,
  input  logic [PortIdWidth+TxIdWidth-1:0]  mem_rtrn_tid_i,
  output logic                              route_err_o
);

  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  typedef logic [PortIdWidth-1:0] port_idx_t;

  // IDLE: free to arbitrate every cycle. LOCKED: a request was presented but
  // not acked, so the grant is frozen on lock_idx_q.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e           state_q, state_d;
  port_idx_t             lock_idx_q, lock_idx_d;
  port_idx_t             rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]   cnt_q [NumPorts];
  logic [CntWidth-1:0]   cnt_d [NumPorts];

  logic [NumPorts-1:0]   rtrn_vld_q, rtrn_vld_d;
  logic [DataWidth-1:0]  rtrn_data_q;
  logic [TxIdWidth-1:0]  rtrn_tid_q;
  logic                  err_q;

  logic [NumPorts-1:0]   eligible;
  logic                  arb_found;
  port_idx_t             arb_idx;
  port_idx_t             gnt_idx;
  logic                  locked;
  logic                  ack;
  port_idx_t             rtrn_port;
  logic                  rtrn_ok;
  logic                  rtrn_bad;
  logic                  underflow;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      eligible[i] = port_req_i[i] && (cnt_q[i] < MaxCnt);
    end
  end

  // Scan ports in rotation order starting at the pointer. The inner loop
  // compares against the constant i instead of indexing with a computed
  // value. This keeps the modulo-NumPorts wrap plain for non-power-of-two
  // port counts.
  always_comb begin : arb_search
    int unsigned cand;
    cand      = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
`ifdef WT_ARB_PORT0_PRIO_EN
    if (eligible[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
`endif
    for (int unsigned k = 0; k < NumPorts; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NumPorts) begin
        cand = cand - NumPorts;
      end
      for (int unsigned i = 0; i < NumPorts; i++) begin
        if (!arb_found && (cand == i) && eligible[i]) begin
          arb_found = 1'b1;
          arb_idx   = port_idx_t'(i);
        end
      end
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign gnt_idx   = locked ? lock_idx_q : arb_idx;
  assign mem_req_o = locked || arb_found;
  assign ack       = mem_req_o && mem_ack_i;

  // ---------------------------------------------------------------------------
  // Request mux and per-port acknowledge
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_we_o    = 1'b0;
    mem_tid_o   = '0;
    port_ack_o  = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (mem_req_o && (gnt_idx == port_idx_t'(i))) begin
        mem_addr_o  = port_addr_i[i*AddrWidth +: AddrWidth];
        mem_wdata_o = port_wdata_i[i*DataWidth +: DataWidth];
        mem_be_o    = port_be_i[i*BeWidth +: BeWidth];
        mem_we_o    = port_we_i[i];
        mem_tid_o   = {gnt_idx, port_tid_i[i*TxIdWidth +: TxIdWidth]};
        port_ack_o[i] = mem_ack_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_o && !mem_ack_i) begin
          state_d    = ST_LOCKED;
          lock_idx_d = arb_idx;
        end
      end
      ST_LOCKED: begin
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ack) begin
`ifdef WT_ARB_PORT0_PRIO_EN
      // Port 0 does not take part in the rotation. Grants to it leave the
      // pointer where it is, and the wrap goes to 1 instead of 0.
      if (gnt_idx != '0) begin
        rr_ptr_d = (32'(gnt_idx) + 32'd1 >= NumPorts) ? port_idx_t'(1) : gnt_idx + 1'b1;
      end
`else
      rr_ptr_d = (32'(gnt_idx) + 32'd1 >= NumPorts) ? '0 : gnt_idx + 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Return routing and outstanding counters
  // ---------------------------------------------------------------------------
  assign rtrn_port = mem_rtrn_tid_i[TxIdWidth +: PortIdWidth];
  assign rtrn_ok   = mem_rtrn_vld_i && (32'(rtrn_port) < NumPorts);
  assign rtrn_bad  = mem_rtrn_vld_i && !(32'(rtrn_port) < NumPorts);

  always_comb begin
    rtrn_vld_d = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      rtrn_vld_d[i] = rtrn_ok && (rtrn_port == port_idx_t'(i));
    end
  end

  // An ack and a return on the same port in one cycle cancel out. A return
  // that would take a counter below zero is still forwarded, but it is
  // flagged.
  always_comb begin
    underflow = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ack && (gnt_idx == port_idx_t'(i)) && !rtrn_vld_d[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rtrn_vld_d[i] && !(ack && (gnt_idx == port_idx_t'(i)))) begin
        if (cnt_q[i] == '0) begin
          underflow = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      lock_idx_q  <= '0;
      rr_ptr_q    <= '0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        cnt_q[i] <= '0;
      end
      rtrn_vld_q  <= '0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int unsigned i = 0; i < NumPorts; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      rtrn_vld_q <= rtrn_vld_d;
      if (rtrn_ok) begin
        rtrn_data_q <= mem_rtrn_data_i;
        rtrn_tid_q  <= mem_rtrn_tid_i[TxIdWidth-1:0];
      end
      err_q <= err_q | rtrn_bad | underflow;
    end
  end

  assign port_rtrn_vld_o  = rtrn_vld_q;
  assign port_rtrn_data_o = rtrn_data_q;
  assign port_rtrn_tid_o  = rtrn_tid_q;
  assign route_err_o      = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Testbench for wt_mem_req_arbiter (NumPorts=3, MaxOutstanding=4).
// Directed scenarios first, then a randomized run with a mid-run reset.
// WT_ARB_PORT0_PRIO_EN selects the priority-mode scenario and model rule.
module tb_wt_mem_req_arbiter;
  localparam int N    = 3;
  localparam int TW   = 2;
  localparam int AW   = 56;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int MAXO = 4;
  localparam int PW   = 2;
  localparam int RW   = N + TW + DW;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- DUT signals ----------------
  logic [N-1:0]       port_req_i = '0;
  logic [N-1:0]       port_ack_o;
  logic [N*AW-1:0]    port_addr_i;
  logic [N*DW-1:0]    port_wdata_i;
  logic [N*BW-1:0]    port_be_i;
  logic [N-1:0]       port_we_i = '0;
  logic [N*TW-1:0]    port_tid_i;
  logic [N-1:0]       port_rtrn_vld_o;
  logic [DW-1:0]      port_rtrn_data_o;
  logic [TW-1:0]      port_rtrn_tid_o;
  logic               mem_req_o;
  logic               mem_ack_i = 1'b0;
  logic [AW-1:0]      mem_addr_o;
  logic [DW-1:0]      mem_wdata_o;
  logic [BW-1:0]      mem_be_o;
  logic               mem_we_o;
  logic [PW+TW-1:0]   mem_tid_o;
  logic               mem_rtrn_vld_i = 1'b0;
  logic [DW-1:0]      mem_rtrn_data_i = '0;
  logic [PW+TW-1:0]   mem_rtrn_tid_i = '0;
  logic               route_err_o;

  logic [AW-1:0] cli_addr  [N];
  logic [DW-1:0] cli_wdata [N];
  logic [BW-1:0] cli_be    [N];
  logic [TW-1:0] cli_tid   [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign port_addr_i[gi*AW +: AW]  = cli_addr[gi];
    assign port_wdata_i[gi*DW +: DW] = cli_wdata[gi];
    assign port_be_i[gi*BW +: BW]    = cli_be[gi];
    assign port_tid_i[gi*TW +: TW]   = cli_tid[gi];
  end

  wt_mem_req_arbiter #(
    .NumPorts(N), .TxIdWidth(TW), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .port_req_i(port_req_i), .port_ack_o(port_ack_o),
    .port_addr_i(port_addr_i), .port_wdata_i(port_wdata_i), .port_be_i(port_be_i),
    .port_we_i(port_we_i), .port_tid_i(port_tid_i),
    .port_rtrn_vld_o(port_rtrn_vld_o), .port_rtrn_data_o(port_rtrn_data_o),
    .port_rtrn_tid_o(port_rtrn_tid_o),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_we_o(mem_we_o), .mem_tid_o(mem_tid_o),
    .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_data_i(mem_rtrn_data_i),
    .mem_rtrn_tid_i(mem_rtrn_tid_i), .route_err_o(route_err_o)
  );

  // ---------------- scoreboard / reporting ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected return outputs, one entry per cycle: {vld one-hot, tid, data}
  logic [RW-1:0]    exp_q[$];
  // Transactions acked and not yet returned: {port, tid}
  logic [PW+TW-1:0] out_q[$];
  // Ports acked, in order
  int               gnt_hist[$];

  // Behavioural model state
  int           m_rr;
  bit           m_locked;
  int           m_lock_port;
  int           m_cnt [N];
  bit           m_err;
  logic [N-1:0] m_ack_vec;

  function automatic int pick(input logic [N-1:0] e, input int ptr);
    logic [N-1:0] s;
`ifdef WT_ARB_PORT0_PRIO_EN
    if (e[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      s = e >> ((ptr + k) % N);
      if (s[0]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  function automatic int next_ptr(input int g, input int cur);
`ifdef WT_ARB_PORT0_PRIO_EN
    if (g == 0) return cur;
    return (g + 1 >= N) ? 1 : g + 1;
`else
    return (g + 1) % N;
`endif
  endfunction

  task automatic model_reset();
    m_rr = 0; m_locked = 0; m_lock_port = 0; m_err = 0; m_ack_vec = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    exp_q.delete();
    exp_q.push_back('0);
    out_q.delete();
    gnt_hist.delete();
  endtask

  always @(negedge clk_i) begin : cmp_proc
    logic [N-1:0]  elig;
    logic [N-1:0]  exp_ack;
    logic [N-1:0]  one_n;
    logic [RW-1:0] e;
    logic [RW-1:0] new_e;
    int            g;
    int            p;
    bit            req;
    bit            ack;
    one_n = 1;
    if (!rst_ni) begin
      model_reset();
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_port_ack", port_ack_o, 0);
      chk("rst_rtrn_vld", port_rtrn_vld_o, 0);
      chk("rst_route_err", route_err_o, 0);
    end else begin
      for (int i = 0; i < N; i++) elig[i] = port_req_i[i] && (m_cnt[i] < MAXO);
      if (m_locked) begin
        req = 1; g = m_lock_port;
      end else begin
        req = (elig != 0); g = pick(elig, m_rr);
      end
      ack = req && mem_ack_i;
      exp_ack = ack ? (one_n << g) : '0;

      chk("mem_req", mem_req_o, req);
      chk("port_ack", port_ack_o, exp_ack);
      if (req) begin
        chk("mem_addr", mem_addr_o, cli_addr[g]);
        chk("mem_wdata", mem_wdata_o, cli_wdata[g]);
        chk("mem_be", mem_be_o, cli_be[g]);
        chk("mem_we", mem_we_o, port_we_i[g]);
        chk("mem_tid", mem_tid_o, {PW'(g), cli_tid[g]});
      end
      e = exp_q.pop_front();
      chk("rtrn_vld", port_rtrn_vld_o, e[RW-1 -: N]);
      if (e[RW-1 -: N] != 0) begin
        chk("rtrn_tid", port_rtrn_tid_o, e[DW +: TW]);
        chk("rtrn_data", port_rtrn_data_o, e[DW-1:0]);
      end
      chk("route_err", route_err_o, m_err);

      // advance the model by one cycle
      if (req && !ack) begin
        m_locked = 1; m_lock_port = g;
      end else if (ack) begin
        m_locked = 0;
      end
      m_ack_vec = exp_ack;
      if (ack) begin
        gnt_hist.push_back(g);
        out_q.push_back({PW'(g), cli_tid[g]});
        m_rr = next_ptr(g, m_rr);
        m_cnt[g]++;
      end
      new_e = '0;
      if (mem_rtrn_vld_i) begin
        p = int'(mem_rtrn_tid_i[PW+TW-1:TW]);
        if (p >= N) begin
          m_err = 1;
        end else begin
          new_e = {one_n << p, mem_rtrn_tid_i[TW-1:0], mem_rtrn_data_i};
          if (ack && g == p) m_cnt[p]--;
          else if (m_cnt[p] == 0) m_err = 1;
          else m_cnt[p]--;
        end
      end
      exp_q.push_back(new_e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    port_req_i = '0; port_we_i = '0; mem_ack_i = 0;
    mem_rtrn_vld_i = 0; mem_rtrn_tid_i = '0; mem_rtrn_data_i = '0;
    for (int i = 0; i < N; i++) begin
      cli_addr[i] = '0; cli_wdata[i] = '0; cli_be[i] = '0; cli_tid[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1;
  endtask

  task automatic set_req(input int i, input logic [TW-1:0] tid);
    port_req_i[i] = 1'b1;
    cli_addr[i]   = AW'({$urandom(), $urandom()});
    cli_wdata[i]  = {$urandom(), $urandom()};
    cli_be[i]     = BW'($urandom());
    port_we_i[i]  = 1'($urandom_range(0, 1));
    cli_tid[i]    = tid;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] held_addr;
    logic [DW-1:0] rdata;
    logic [TW-1:0] last_tid;
    int            exp_g[6];
    int            idx;

    // Round robin over three continuously requesting ports
    do_reset();
    chk("reset_err_literal", route_err_o, 0);
    for (int i = 0; i < N; i++) set_req(i, TW'(i));
    mem_ack_i = 1;
    repeat (6) begin
      step();
      for (int i = 0; i < N; i++) if (m_ack_vec[i]) set_req(i, cli_tid[i] + 1'b1);
    end
    exp_g = '{0, 1, 2, 0, 1, 2};
    chk("rr_hist_len", gnt_hist.size(), 6);
    for (int k = 0; k < 6 && k < gnt_hist.size(); k++) chk("rr_hist", gnt_hist[k], exp_g[k]);

    // Held request stays locked while port 0 arrives
    do_reset();
    set_req(1, 2'd1);
    held_addr = cli_addr[1];
    for (int c = 0; c < 5; c++) begin
      if (c == 2) set_req(0, 2'd0);
      @(negedge clk_i);
      chk("lock_addr", mem_addr_o, held_addr);
      chk("lock_tid", mem_tid_o, 4'b0101);
      step();
    end
    mem_ack_i = 1;
    @(negedge clk_i);
    chk("lock_ack_p1", port_ack_o, 3'b010);
    step();
    port_req_i[1] = 0;
    @(negedge clk_i);
    chk("after_lock_ack_p0", port_ack_o, 3'b001);
    step();
    clear_inputs();
    chk("lock_hist_len", gnt_hist.size(), 2);
    if (gnt_hist.size() == 2) begin
      chk("lock_hist0", gnt_hist[0], 1);
      chk("lock_hist1", gnt_hist[1], 0);
    end

    // Outstanding limit on port 0, released by one return
    do_reset();
    set_req(0, 2'd0);
    mem_ack_i = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (m_ack_vec[0]) set_req(0, TW'(k));
    end
    mem_ack_i = 0;
    @(negedge clk_i);
    chk("full_block", mem_req_o, 0);
    step();
    rdata = {$urandom(), $urandom()};
    mem_rtrn_vld_i = 1; mem_rtrn_tid_i = {2'd0, 2'b11}; mem_rtrn_data_i = rdata;
    @(negedge clk_i);
    chk("full_block_rtrn_cycle", mem_req_o, 0);
    step();
    mem_rtrn_vld_i = 0; mem_ack_i = 1;
    @(negedge clk_i);
    chk("rtrn_vld_p0", port_rtrn_vld_o, 3'b001);
    chk("rtrn_tid_p0", port_rtrn_tid_o, 2'd3);
    chk("rtrn_data_p0", port_rtrn_data_o, rdata);
    chk("unblocked_req", mem_req_o, 1);
    chk("unblocked_ack", port_ack_o, 3'b001);
    step();
    clear_inputs();

    // Ack and return on port 1 in the same cycle keep the count unchanged
    do_reset();
    set_req(1, 2'd0);
    mem_ack_i = 1;
    step(); set_req(1, 2'd1);
    step(); set_req(1, 2'd2);
    mem_rtrn_vld_i = 1; mem_rtrn_tid_i = {2'd1, 2'd0}; mem_rtrn_data_i = {$urandom(), $urandom()};
    @(negedge clk_i);
    chk("same_cycle_ack", port_ack_o, 3'b010);
    step(); set_req(1, 2'd3);
    mem_rtrn_vld_i = 0;
    @(negedge clk_i);
    chk("same_cycle_rtrn", port_rtrn_vld_o, 3'b010);
    chk("cnt3_ack", port_ack_o, 3'b010);
    step(); set_req(1, 2'd0);
    @(negedge clk_i);
    chk("cnt4_ack", port_ack_o, 3'b010);
    step(); set_req(1, 2'd1);
    mem_ack_i = 0;
    @(negedge clk_i);
    chk("cnt_full_p1", mem_req_o, 0);
    step();
    clear_inputs();

    // Bad port field and sticky error, then underflow
    do_reset();
    mem_rtrn_vld_i = 1; mem_rtrn_tid_i = 4'b1100; mem_rtrn_data_i = {$urandom(), $urandom()};
    step();
    mem_rtrn_vld_i = 0;
    @(negedge clk_i);
    chk("bad_port_no_rtrn", port_rtrn_vld_o, 3'b000);
    chk("bad_port_err", route_err_o, 1);
    repeat (5) step();
    @(negedge clk_i);
    chk("err_sticky", route_err_o, 1);
    step();
    rst_ni = 0;
    #1;
    chk("err_cleared_by_reset", route_err_o, 0);
    do_reset();
    mem_rtrn_vld_i = 1; mem_rtrn_tid_i = {2'd2, 2'd1}; mem_rtrn_data_i = {$urandom(), $urandom()};
    step();
    mem_rtrn_vld_i = 0;
    @(negedge clk_i);
    chk("underflow_fwd", port_rtrn_vld_o, 3'b100);
    chk("underflow_tid", port_rtrn_tid_o, 2'd1);
    chk("underflow_err", route_err_o, 1);
    step();

`ifdef WT_ARB_PORT0_PRIO_EN
    // Port 0 priority starves port 1 until port 0 drops
    do_reset();
    set_req(0, 2'd0); set_req(1, 2'd0);
    mem_ack_i = 1;
    for (int c = 0; c < 6; c++) begin
      step();
      last_tid = cli_tid[0];
      if (m_ack_vec[0]) set_req(0, cli_tid[0] + 1'b1);
      mem_rtrn_vld_i = 1; mem_rtrn_tid_i = {2'd0, last_tid};
      mem_rtrn_data_i = {$urandom(), $urandom()};
    end
    port_req_i[0] = 0;
    step();
    mem_rtrn_vld_i = 0;
    step();
    clear_inputs();
    chk("prio_hist_len", gnt_hist.size(), 8);
    for (int k = 0; k < 6 && k < gnt_hist.size(); k++) chk("prio_p0", gnt_hist[k], 0);
    if (gnt_hist.size() > 6) chk("prio_p1_after_drop", gnt_hist[6], 1);
`else
    // Two ports alternate under pure round robin
    do_reset();
    set_req(0, 2'd0); set_req(1, 2'd0);
    mem_ack_i = 1;
    repeat (4) begin
      step();
      for (int i = 0; i < N; i++) if (m_ack_vec[i]) set_req(i, cli_tid[i] + 1'b1);
    end
    clear_inputs();
    chk("alt_hist_len", gnt_hist.size(), 4);
    for (int k = 0; k < 4 && k < gnt_hist.size(); k++) chk("alt_hist", gnt_hist[k], k % 2);
    last_tid = '0;
`endif

    // Randomized traffic with a mid-run reset
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      for (int i = 0; i < N; i++) begin
        if (port_req_i[i] && m_ack_vec[i]) port_req_i[i] = 0;
        if (!port_req_i[i] && $urandom_range(0, 99) < 50) set_req(i, TW'($urandom()));
      end
      mem_ack_i = ($urandom_range(0, 99) < 60);
      if (out_q.size() > 0 && $urandom_range(0, 99) < 45) begin
        idx = $urandom_range(0, out_q.size() - 1);
        mem_rtrn_vld_i = 1;
        mem_rtrn_tid_i = out_q[idx];
        out_q.delete(idx);
      end else begin
        mem_rtrn_vld_i = 0;
        mem_rtrn_tid_i = (PW+TW)'($urandom());
      end
      mem_rtrn_data_i = {$urandom(), $urandom()};
      step();
    end
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Parametrised N-port request arbiter and return router between L1 cache clients (I$, D$, future PTW/accelerator caches) and a single memory adapter (AXI or L1.5).
- Generalises the fixed two-client plumbing of the cache subsystem to NumPorts clients.
- Adds round-robin arbitration, port-index tagging of transaction IDs, per-port outstanding-transaction limits and registered return routing.

Parameters:
- NumPorts, 2, number of cache clients (2..8).
- TxIdWidth, 2, client-side transaction ID width.
- AddrWidth, 56, physical address width.
- DataWidth, 64, request/return data width.
- MaxOutstanding, 4, maximum un-returned transactions per port (1..15).
- PortIdWidth, $clog2(NumPorts) (min 1), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- port_req_i  in  NumPorts  per-port request valid; held until acked.
- port_ack_o  out  NumPorts  per-port one-cycle acknowledge.
- port_addr_i  in  NumPorts*AddrWidth  request address.
- port_wdata_i  in  NumPorts*DataWidth  write data.
- port_be_i  in  NumPorts*(DataWidth/8)  byte enables.
- port_we_i  in  NumPorts  1=store, 0=load.
- port_tid_i  in  NumPorts*TxIdWidth  client transaction ID.
- port_rtrn_vld_o  out  NumPorts  return valid, one-hot or zero.
- port_rtrn_data_o  out  DataWidth  return data, shared by all ports.
- port_rtrn_tid_o  out  TxIdWidth  return ID, port field stripped.
- mem_req_o  out  1  request to adapter.
- mem_ack_i  in  1  adapter acknowledge.
- mem_addr_o / mem_wdata_o / mem_be_o / mem_we_o  out  widths as above  granted request fields.
- mem_tid_o  out  PortIdWidth+TxIdWidth  {port index, client tid}.
- mem_rtrn_vld_i  in  1  return valid.
- mem_rtrn_data_i  in  DataWidth  return data.
- mem_rtrn_tid_i  in  PortIdWidth+TxIdWidth  return ID.
- route_err_o  out  1  sticky: bad return port field or counter underflow.

Behaviour:
- Reset values: all outputs 0; RR pointer 0; lock 0; all outstanding counters 0.
- Eligibility: port i is eligible when port_req_i[i] is high and cnt[i] < MaxOutstanding.
- Arbitration (unlocked): grant the first eligible port at or after the RR pointer, wrapping modulo NumPorts. mem_req_o = any eligible. mem_* fields are driven combinationally from the grantee.
- Lock: if mem_req_o is high and mem_ack_i is low, register lock=1 and the grantee. While locked the grant is frozen and no re-arbitration happens, even if higher-rotation ports rise. The handshake follows the req/ack rule: request fields stay stable until acked.
- Ack: mem_ack_i (only valid while mem_req_o is high) drives port_ack_o[grantee] for that same cycle. Lock clears; RR pointer <= grantee+1 (wrap to 0). cnt[grantee]++.
- Return path, 1-cycle registered latency: on mem_rtrn_vld_i with port field p < NumPorts, next cycle port_rtrn_vld_o[p]=1, data and tid (low TxIdWidth bits) registered. cnt[p]--.
- Simultaneous ack and return on the same port: counter unchanged.
- Bad port field: p >= NumPorts → return dropped, route_err_o set.
- Underflow: return to a port with cnt=0 → return still forwarded, counter stays 0, route_err_o set.
- route_err_o clears only on reset.
- Full: a port with cnt=MaxOutstanding is masked. If it is already locked it stays granted; the limit is checked only at arbitration.
- Reset mid-handshake clears the lock, all counters and the pipeline register; in-flight returns are then unmatched, and the system must reset the adapter together with this block.
- mem_ack_i while mem_req_o is low: ignored.

Optional Feature:
- Macro: WT_ARB_PORT0_PRIO_EN.
- Defined: port 0 (I$) has strict priority. When unlocked and port 0 is eligible it is granted regardless of the RR pointer. Other ports rotate round-robin among themselves, and the pointer never advances to 0.
- Undefined: pure round-robin over all ports as above.
- Lock, limit and routing are identical in both modes.

Test Plan:
- NumPorts=3; ports 0,1,2 request continuously; adapter acks every cycle → grants 0,1,2,0,1,2; mem_tid_o port field is 0,1,2; exactly one port_ack_o per ack.
- Port 1 requests, adapter holds ack low 5 cycles, port 0 rises in cycle 2 → mem_addr_o and mem_tid_o are stable for all 5 cycles; grant stays port 1; port_ack_o[1] on the ack cycle; port 0 granted next.
- MaxOutstanding=4; port 0 issues 4 acked loads, no returns → 5th request is not presented (mem_req_o=0 if alone). One return with tid {0,2'b11} → port_rtrn_vld_o[0] one cycle later, port_rtrn_tid_o=3; request then accepted.
- Ack for port 1 and return for port 1 in the same cycle with cnt[1]=2 → cnt[1] stays 2; port_rtrn_vld_o[1] next cycle.
- NumPorts=3; return with port field 3 → no port_rtrn_vld_o asserted; route_err_o=1 and stays high until rst_ni low.
- With WT_ARB_PORT0_PRIO_EN, ports 0 and 1 request continuously with single-cycle acks → port 0 granted every cycle and port 1 starves. Port 0 drops → port 1 granted on the next cycle.
